freq_duty_monitor: RTL and testbench

//  Downstream checker for the clock-divider outputs (e.g. the divide-by-3 clk_out).

---
 rtl/freq_duty_monitor.sv | 158 +++++++++++++++
 tb/tb_freq_duty_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/freq_duty_monitor.sv
// freq_duty_monitor: measures the period and high time of a divided clock,
// sampled in the clk_in domain. One result is published per completed period.
// A sticky timeout is raised when no complete period arrives in 2**CNT_W-1 cycles.
//
// Output semantics: meas_valid is a single-cycle strobe with no back-pressure.
// period/high_time change only in the cycle meas_valid is high, and hold otherwise.
// The FSM state is visible to checkers as state_q.
module freq_duty_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic             sig_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hcnt_inc;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~prev_q;
  assign fall  = ~sig_s & prev_q;

  // Saturating increments: the counters can never wrap, even on a fall at MAX.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;

  // Synchroniser chain and edge-detect register; runs regardless of enable.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sig_s;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!enable) begin
      // Abort the measurement but keep the last results and the timeout flag.
      state_d = WAIT_RISE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS_HIGH;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            state_d = MEAS_LOW;
            cnt_d   = cnt_inc;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = WAIT_RISE;
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d  = cnt_inc;
            hcnt_d = hcnt_inc;
          end
        end
        MEAS_LOW: begin
          // A rise takes priority over the MAX check, so a period of MAX is valid.
          if (rise) begin
            state_d   = MEAS_HIGH;
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = WAIT_RISE;
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= WAIT_RISE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_freq_duty_monitor.sv
// Bench for freq_duty_monitor with CNT_W=4 so timeout and MAX-period cases are short.
// Every driven rise that completes a period pushes {period, high_time} onto exp_q;
// a monitor pops and compares on every meas_valid.
module tb_freq_duty_monitor;

  localparam int W = 4;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic         enable = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] pend;
  bit             pend_v = 1'b0;

  freq_duty_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one posedge and land on the following negedge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a rise; the previous pulse (if armed) completes here.
  task automatic rise_edge();
    if (pend_v) exp_q.push_back(pend);
    sig_in = 1'b1;
  endtask

  task automatic pulse(input int h, input int l);
    rise_edge();
    pend   = {W'(h + l), W'(h)};
    pend_v = 1'b1;
    ticks(h);
    sig_in = 1'b0;
    ticks(l);
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(meas_valid), 32'd0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check_eq("period", 32'(period), 32'(e[2*W-1:W]));
        check_eq("high_time", 32'(high_time), 32'(e[W-1:0]));
        check_eq("timeout_on_valid", 32'(timeout), 32'd0);
      end
    end
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    ticks(3);
    check_eq("rst_period", 32'(period), 32'd0);
    check_eq("rst_high", 32'(high_time), 32'd0);
    check_eq("rst_valid", 32'(meas_valid), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Divide-by-3 pattern
    repeat (6) pulse(1, 2);

    // 4/4 then 2/6
    repeat (3) pulse(4, 4);
    repeat (2) pulse(2, 6);

    // Latency: sig_in sampled high at edge k -> meas_valid after edge k+2
    rise_edge();
    pend   = {W'(6), W'(3)};
    pend_v = 1'b1;
    tick();
    check_eq("lat_k", 32'(meas_valid), 32'd0);
    tick();
    check_eq("lat_k1", 32'(meas_valid), 32'd0);
    tick();
    check_eq("lat_k2", 32'(meas_valid), 32'd1);
    sig_in = 1'b0;
    ticks(3);

    // Reset mid-MEAS_LOW
    pulse(2, 2);
    ticks(2);
    rst_n  = 1'b0;
    pend_v = 1'b0;
    tick();
    check_eq("mid_rst_period", 32'(period), 32'd0);
    check_eq("mid_rst_high", 32'(high_time), 32'd0);
    check_eq("mid_rst_valid", 32'(meas_valid), 32'd0);
    check_eq("mid_rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    pulse(3, 3);
    pulse(3, 3);

    // Enable low for 5 cycles in the low phase
    pulse(4, 4);
    enable = 1'b0;
    pend_v = 1'b0;
    ticks(5);
    enable = 1'b1;
    tick();
    pulse(4, 4);
    pulse(4, 4);

    // Stuck high -> timeout, results held
    pulse(4, 4);
    rise_edge();
    pend_v = 1'b0;
    ticks(17);
    check_eq("to_before", 32'(timeout), 32'd0);
    tick();
    check_eq("to_set", 32'(timeout), 32'd1);
    check_eq("to_hold_period", 32'(period), 32'd8);
    check_eq("to_hold_high", 32'(high_time), 32'd4);
    ticks(3);
    check_eq("to_sticky", 32'(timeout), 32'd1);
    sig_in = 1'b0;
    ticks(3);
    pulse(3, 3);
    pulse(3, 3);

    // Period exactly MAX (15)
    pulse(7, 8);
    pulse(7, 8);
    check_eq("max_no_timeout", 32'(timeout), 32'd0);
    pulse(7, 8);
    pulse(2, 2);
    ticks(6);
    check_eq("max_after_timeout", 32'(timeout), 32'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
